// File: rtl/dsp_seq_pkg.sv
// Shared constants and FSM state type for the dot-product sequencer.
package dsp_seq_pkg;

    localparam int DWIDTH   = 8;
    localparam int LEN_W    = 4;
    localparam int MODE_DLY = 2;  // operand cycle to mode cycle
    localparam int RES_LAT  = 3;  // operand cycle to result-sample cycle

    // Mode tag carried alongside each operand cycle: {multiply, accumulate, last}
    localparam int TAG_W    = 3;
    localparam int TAG_MUL  = 2;
    localparam int TAG_ACC  = 1;
    localparam int TAG_LAST = 0;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StHold
    } state_e;

endpackage

// File: rtl/dsp_mode_delay.sv
// Shift register that lines up mode tags with the slice's internal pipeline.
module dsp_mode_delay
    import dsp_seq_pkg::*;
#(
    parameter int STAGES = MODE_DLY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] i_tag,
    output logic [TAG_W-1:0] o_tag
);

    logic [TAG_W-1:0] r_pipe [STAGES];

    // Advance unconditionally so in-flight modes are never dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < STAGES; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[STAGES-1];

endmodule

// File: rtl/dsp_dot_seq.sv
// Dot-product sequencer driving an external int8 multiply/accumulate slice.
module dsp_dot_seq #(
    parameter int DWIDTH = dsp_seq_pkg::DWIDTH,
    parameter int LEN_W  = dsp_seq_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DWIDTH-1:0] i_in_a,
    input  logic [DWIDTH-1:0] i_in_b,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DWIDTH-1:0] o_out_data,
    output logic [DWIDTH-1:0] o_slice_ax,
    output logic [DWIDTH-1:0] o_slice_ay,
    output logic [DWIDTH-1:0] o_slice_az,
    output logic              o_slice_multiply,
    output logic              o_slice_accumulate,
    output logic              o_slice_carry_in,
    input  logic [DWIDTH-1:0] i_slice_result
);

    import dsp_seq_pkg::*;

    state_e            r_state;
    logic [LEN_W-1:0]  r_count;
    logic              r_first;
    logic              r_cmd_ready;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_data;
    logic [DWIDTH-1:0] r_ay;
    logic [DWIDTH-1:0] r_az;
    logic [TAG_W-1:0]  r_tag;
    logic              r_last_res;   // last pair's result is on slice_result this cycle
    logic [TAG_W-1:0]  w_tag_dly;
    logic              w_in_fire;

    assign w_in_fire = r_in_ready && i_in_valid;

    // Mode tags registered alongside operands, then delayed to the slice's mode cycle
    dsp_mode_delay #(
        .STAGES (MODE_DLY)
    ) u_mode_delay (
        .clk   (clk),
        .reset (reset),
        .i_tag (r_tag),
        .o_tag (w_tag_dly)
    );

    // Command FSM with registered handshakes, slice operands and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_first     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ay        <= '0;
            r_az        <= '0;
            r_tag       <= '0;
            r_last_res  <= 1'b0;
        end else begin
            // Operands and tag default to zero; only STREAM overrides them
            r_ay       <= '0;
            r_az       <= '0;
            r_tag      <= '0;
            r_last_res <= w_tag_dly[TAG_LAST];
            case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (i_cmd_len != '0) begin
                            r_count    <= i_cmd_len;
                            r_first    <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_state    <= StStream;
                        end else begin
                            r_out_data  <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= StHold;
                        end
                    end
                end
                StStream: begin
                    if (w_in_fire) begin
                        r_ay           <= i_in_a;
                        r_az           <= i_in_b;
                        r_tag[TAG_MUL] <= r_first;
                        r_tag[TAG_ACC] <= !r_first;
                        r_tag[TAG_LAST] <= (r_count == LEN_W'(1));
                        r_first        <= 1'b0;
                        r_count        <= r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= StDrain;
                        end
                    end else begin
                        // Bubble: zero operands, accumulate adds nothing
                        r_tag[TAG_ACC] <= 1'b1;
                    end
                end
                StDrain: begin
                    if (r_last_res) begin
                        r_out_data  <= i_slice_result;
                        r_out_valid <= 1'b1;
                        r_state     <= StHold;
                    end
                end
                StHold: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready        = r_cmd_ready;
    assign o_in_ready         = r_in_ready;
    assign o_out_valid        = r_out_valid;
    assign o_out_data         = r_out_data;
    assign o_slice_ax         = '0;
    assign o_slice_ay         = r_ay;
    assign o_slice_az         = r_az;
    assign o_slice_multiply   = w_tag_dly[TAG_MUL];
    assign o_slice_accumulate = w_tag_dly[TAG_ACC];
    assign o_slice_carry_in   = 1'b0;

endmodule

// File: tb/tb_dsp_dot_seq.sv
// Directed bench for dsp_dot_seq with a behavioural int8 slice model.
module tb_dsp_dot_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_cmd_valid, o_cmd_ready;
    logic [3:0] i_cmd_len;
    logic       i_in_valid, o_in_ready;
    logic [7:0] i_in_a, i_in_b;
    logic       o_out_valid, i_out_ready;
    logic [7:0] o_out_data;
    logic [7:0] o_slice_ax, o_slice_ay, o_slice_az;
    logic       o_slice_multiply, o_slice_accumulate, o_slice_carry_in;
    logic [7:0] i_slice_result;

    int n_checks = 0;
    int n_errors = 0;

    dsp_dot_seq dut (
        .clk                (clk),
        .reset              (reset),
        .i_cmd_valid        (i_cmd_valid),
        .o_cmd_ready        (o_cmd_ready),
        .i_cmd_len          (i_cmd_len),
        .i_in_valid         (i_in_valid),
        .o_in_ready         (o_in_ready),
        .i_in_a             (i_in_a),
        .i_in_b             (i_in_b),
        .o_out_valid        (o_out_valid),
        .i_out_ready        (i_out_ready),
        .o_out_data         (o_out_data),
        .o_slice_ax         (o_slice_ax),
        .o_slice_ay         (o_slice_ay),
        .o_slice_az         (o_slice_az),
        .o_slice_multiply   (o_slice_multiply),
        .o_slice_accumulate (o_slice_accumulate),
        .o_slice_carry_in   (o_slice_carry_in),
        .i_slice_result     (i_slice_result)
    );

    always #5 clk = ~clk;

    // Slice model: operands registered, saturated product registered, then mode-driven result
    function automatic logic [7:0] sat8(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        if (p > 127) return 8'h7F;
        if (p < -128) return 8'h80;
        return p[7:0];
    endfunction

    logic [7:0] m_ax, m_ay, m_az, m_p, m_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_ax <= '0; m_ay <= '0; m_az <= '0; m_p <= '0; m_res <= '0;
        end else begin
            m_ax <= o_slice_ax;
            m_ay <= o_slice_ay;
            m_az <= o_slice_az;
            m_p  <= sat8(m_ay, m_az) + m_ax + {7'd0, o_slice_carry_in};
            if (o_slice_multiply)        m_res <= m_p;
            else if (o_slice_accumulate) m_res <= m_res + m_p;
        end
    end
    assign i_slice_result = m_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] len;
        logic [7:0] a [3];
        logic [7:0] b [3];
        int         gap_at;   // element index preceded by idle cycles (-1: none)
        int         gap_n;
        int         hold_n;   // cycles out_ready stays low while result is offered
        logic [7:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] len,
                                input logic [7:0] a0, input logic [7:0] b0,
                                input logic [7:0] a1, input logic [7:0] b1,
                                input logic [7:0] a2, input logic [7:0] b2,
                                input int gap_at, input int gap_n, input int hold_n,
                                input logic [7:0] exp);
        vec_t v;
        v.len = len;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.gap_at = gap_at; v.gap_n = gap_n; v.hold_n = hold_n;
        v.exp = exp;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        check({tag, " cmd_ready idle"}, int'(o_cmd_ready), 1);
        check({tag, " idle mode bits"}, int'({o_slice_multiply, o_slice_accumulate}), 0);
        i_cmd_valid = 1'b1;
        i_cmd_len   = v.len;
        tick();
        i_cmd_valid = 1'b0;
        for (int k = 0; k < int'(v.len); k++) begin
            if (k == v.gap_at) begin
                i_in_valid = 1'b0;
                repeat (v.gap_n) tick();
            end
            i_in_valid = 1'b1;
            i_in_a = v.a[k];
            i_in_b = v.b[k];
            n = 0;
            while (!o_in_ready && n < 20) begin
                tick();
                n++;
            end
            check({tag, " in_ready"}, int'(o_in_ready), 1);
            tick();
            i_in_valid = 1'b0;
        end
        n = 0;
        while (!o_out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " out_valid"}, int'(o_out_valid), 1);
        check({tag, " out_data"}, int'(o_out_data), int'(v.exp));
        for (int h = 0; h < v.hold_n; h++) begin
            tick();
            check({tag, " hold out_data"}, int'(o_out_data), int'(v.exp));
            check({tag, " hold cmd_ready"}, int'(o_cmd_ready), 0);
            check({tag, " hold out_valid"}, int'(o_out_valid), 1);
        end
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        check({tag, " cmd_ready after"}, int'(o_cmd_ready), 1);
        check({tag, " out_valid after"}, int'(o_out_valid), 0);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = mk(4'd1, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, 0, 8'h0C);
        vecs[1] = mk(4'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 2, 2, 0, 8'd44);
        vecs[2] = mk(4'd1, 8'd20, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, 0, 8'h7F);
        vecs[3] = mk(4'd1, 8'hEC, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, 0, 8'h80);
        vecs[4] = mk(4'd2, 8'd100, 8'd1, 8'd100, 8'd1, 8'd0, 8'd0, -1, 0, 0, 8'hC8);
        vecs[5] = mk(4'd1, 8'hFD, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, 0, 8'hF1);
        vecs[6] = mk(4'd0, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, 0, 8'h00);
        vecs[7] = mk(4'd3, 8'd7, 8'd2, 8'hFF, 8'd3, 8'd2, 8'd2, -1, 0, 5, 8'h0F);

        reset = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_len = '0;
        i_in_valid = 1'b0; i_in_a = '0; i_in_b = '0;
        i_out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset cmd_ready", int'(o_cmd_ready), 1);
        check("reset in_ready", int'(o_in_ready), 0);
        check("reset out_valid", int'(o_out_valid), 0);
        check("reset out_data", int'(o_out_data), 0);
        check("reset slice ops", int'({o_slice_ax, o_slice_ay, o_slice_az}), 0);
        check("reset slice mode", int'({o_slice_multiply, o_slice_accumulate, o_slice_carry_in}),
              0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a stream: the command must vanish without a result
        i_cmd_valid = 1'b1;
        i_cmd_len   = 4'd3;
        tick();
        i_cmd_valid = 1'b0;
        i_in_valid = 1'b1; i_in_a = 8'd9; i_in_b = 8'd9;
        tick();
        i_in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("abort out_valid", int'(o_out_valid), 0);
            tick();
        end
        check("abort in_ready", int'(o_in_ready), 0);
        check("abort out_data", int'(o_out_data), 0);
        run_vec(mk(4'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, -1, 0, 0, 8'd6), "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dsp_dot_seq.md
DSP_DOT_SEQ -- requirements
Module: dsp_dot_seq

Interface
REQ-001 Parameter: DWIDTH, default 8, operand/result width (signed two's complement).
REQ-002 Parameter: LEN_W, default 4, width of the element count.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  dot-product command handshake.
REQ-006 cmd_len  input  LEN_W  number of element pairs in the command (0..15).
REQ-007 in_valid / in_ready  input / output  1 / 1  element-pair stream handshake.
REQ-008 in_a, in_b  input  DWIDTH each  signed element pair.
REQ-009 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-010 out_data  output  DWIDTH  dot-product result.
REQ-011 slice_ax, slice_ay, slice_az  output  DWIDTH each  operands to the int8 DSP slice.
REQ-012 slice_multiply, slice_accumulate, slice_carry_in  output  1 each  slice mode controls; carry_in tied 0.
REQ-013 slice_result  input  DWIDTH  registered slice output.

Function
REQ-014 Slice timing contract: operands presented in cycle c SHALL have their mode bits driven in cycle c+2, and the result SHALL be sampled from slice_result in cycle c+3.
REQ-015 FSM states SHALL be IDLE, STREAM, DRAIN, HOLD.
REQ-016 IDLE: cmd_ready=1; on cmd_valid with cmd_len>0, latch the count and go to STREAM; with cmd_len=0, set out_data=0 and go to HOLD.
REQ-017 STREAM: in_ready=1 while remaining count>0; each accepted pair SHALL be driven on slice_ay=in_a and slice_az=in_b the next cycle, with slice_ax=0.
REQ-018 The first element of a command SHALL carry mode multiply=1, accumulate=0; every later element and every bubble SHALL carry multiply=0, accumulate=1.
REQ-019 Bubble cycles (no pair accepted in STREAM) SHALL drive ay=az=0, so they add zero.
REQ-020 After the last pair is accepted, the FSM SHALL go to DRAIN and wait until that pair's c+3 cycle, then register slice_result into out_data and go to HOLD.
REQ-021 HOLD: out_valid=1, out_data stable until out_ready; on handshake, return to IDLE.
REQ-022 cmd_ready and in_ready SHALL be 0 outside IDLE and STREAM respectively; no overlap of commands.
REQ-023 Arithmetic is defined by the slice: each product is saturated to [-128,127]; the sum wraps modulo 2^DWIDTH; slice carry_out is ignored.
REQ-024 Outside STREAM/DRAIN, slice operands SHALL be 0 and both mode bits 0.
REQ-025 The mode delay pipe SHALL keep advancing in every state so that in-flight modes are never dropped.

Reset
REQ-026 On reset: state=IDLE; cmd_ready=1; in_ready=0; out_valid=0; out_data=0; all slice outputs=0; count and mode pipe cleared.
REQ-027 Reset mid-stream SHALL abandon the command; no out_valid for it, and the next command SHALL be correct.

Structure
REQ-028 Package dsp_seq_pkg SHALL hold DWIDTH, LEN_W, MODE_DLY=2, RES_LAT=3 and the state enum.
REQ-029 Sub-module dsp_mode_delay (2-stage shift register of {multiply, accumulate, last}) SHALL be used; the slice itself is instantiated outside this block.

Verification
REQ-030 len=1, (3,4) -> out_data=12 (0x0C).
REQ-031 len=3, (1,2),(3,4),(5,6) with in_valid low 2 cycles between pairs 2 and 3 -> out_data=44.
REQ-032 len=1, (20,10) -> 127 (0x7F); len=1, (-20,10) -> -128 (0x80), saturated product.
REQ-033 len=2, (100,1),(100,1) -> 0xC8, wrapped; len=1, (-3,5) -> 0xF1.
REQ-034 out_ready held low 5 cycles -> out_data stable, cmd_ready=0 throughout; cmd_len=0 -> out_data=0.
REQ-035 Reset asserted mid-STREAM -> no out_valid; next len=1 (2,3) -> 6.
